// File: rtl/cic_interp_chan_sched.sv
// Round-robin scheduler feeding one shared 3-stage CIC interpolator from NCH sources.
// Optional per-burst underrun counter output enabled by CIC_SCHED_UNDERRUN_CNT_EN.
module cic_interp_chan_sched #(
  parameter int NCH       = 4,
  parameter int CW        = 2,
  parameter int DW        = 8,
  parameter int BURST_LEN = 16,
  parameter int FLUSH_CYC = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [NCH-1:0]    ch_ready,
  output logic [DW-1:0]     x_out,
  output logic              x_valid,
  output logic              cic_rst_n,
  output logic [CW-1:0]     active_ch,
  output logic              busy
`ifdef CIC_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  localparam int MAXC = (BURST_LEN > FLUSH_CYC) ? BURST_LEN : FLUSH_CYC;
  localparam int CNTW = $clog2(MAXC) + 1;
  localparam int NP   = 1 << CW;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0]   r_last, w_last_nxt;
  logic [CW-1:0]   r_active, w_active_nxt;
  logic [DW-1:0]   r_x, w_x_nxt;
  logic            r_xv, w_xv_nxt;
  logic            r_rstn, w_rstn_nxt;

  logic [NP-1:0]   w_vpad;
  logic [NP-1:0]   w_rdy_pad;
  logic [DW-1:0]   w_darr [NP];
  logic            w_any;
  logic [CW-1:0]   w_grant;
  logic            w_vsel;
  int unsigned     w_idx;

  // Pad the request/data views to 2^CW entries so a CW-bit index is always in range.
  assign w_vpad = NP'(ch_valid);
  for (genvar k = 0; k < NP; k++) begin : g_darr
    if (k < NCH) begin : g_real
      assign w_darr[k] = ch_data[k*DW +: DW];
    end else begin : g_pad
      assign w_darr[k] = '0;
    end
  end

  assign w_vsel = w_vpad[r_active];

  // Upward search from last_grant+1 so the previous winner is checked last.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      w_idx = (32'(r_last) + i) % NCH;
      if (!w_any && w_vpad[CW'(w_idx)]) begin
        w_any   = 1'b1;
        w_grant = CW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_active_nxt = r_active;
    w_x_nxt      = '0;
    w_xv_nxt     = 1'b0;
    w_rstn_nxt   = r_rstn;
    case (r_state)
      IDLE: begin
        w_rstn_nxt = 1'b0;
        if (w_any) begin
          w_active_nxt = w_grant;
          w_last_nxt   = w_grant;
          w_cnt_nxt    = '0;
          w_rstn_nxt   = 1'b1;
          w_state_nxt  = STREAM;
        end
      end
      STREAM: begin
        if (w_vsel) begin
          w_x_nxt  = w_darr[r_active];
          w_xv_nxt = 1'b1;
        end
        if (r_cnt == CNTW'(BURST_LEN - 1)) begin
          w_cnt_nxt   = '0;
          w_rstn_nxt  = 1'b0;
          w_state_nxt = FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      FLUSH: begin
        w_rstn_nxt = 1'b0;
        if (r_cnt == CNTW'(FLUSH_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rstn_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= CW'(NCH - 1);
      r_active <= '0;
      r_x      <= '0;
      r_xv     <= 1'b0;
      r_rstn   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      r_active <= w_active_nxt;
      r_x      <= w_x_nxt;
      r_xv     <= w_xv_nxt;
      r_rstn   <= w_rstn_nxt;
    end
  end

  assign w_rdy_pad = (r_state == STREAM) ? (NP'(1) << r_active) : '0;
  assign ch_ready  = w_rdy_pad[NCH-1:0];
  assign x_out     = r_x;
  assign x_valid   = r_xv;
  assign cic_rst_n = r_rstn;
  assign active_ch = r_active;
  assign busy      = (r_state != IDLE);

`ifdef CIC_SCHED_UNDERRUN_CNT_EN
  logic [7:0] r_urc;

  // Cleared on the granting edge so the count covers exactly one burst.
  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_urc <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_urc <= '0;
    end else if (r_state == STREAM && !w_vsel && r_urc != 8'hFF) begin
      r_urc <= r_urc + 8'd1;
    end
  end

  assign underrun_cnt = r_urc;
`endif

endmodule
